grid_sram_seq: RTL and testbench
================================

GRID_SRAM_SEQ -- requirements
Module: grid_sram_seq

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 - WIDTH, 16, data word width
 - ROWS, 10, number of rows
 - COLS, 10, number of columns
 - RW, 4, row address width
 - CW, 4, column address width
REQ-002 Ports SHALL be (name, direction, width, meaning):
 - clk  in  1  single clock; all state updates on rising edge
 - rst  in  1  asynchronous, active-high reset
 - en  in  1  access enable; replaces gated clock, no clock gating inside block
 - we  in  1  write enable for single access
 - row  in  RW  access row
 - col  in  CW  access column
 - m2result  in  WIDTH  write source 0
 - lutdata  in  WIDTH  write source 1
 - inmuxsel  in  1  0 selects m2result, 1 selects lutdata
 - clr_start  in  1  start full-array clear
 - scan_start  in  1  start row scan
 - scan_row  in  RW  row to scan
 - rdata  out  WIDTH  registered read data
 - rvalid  out  1  rdata valid this cycle
 - busy  out  1  sequencer active (CLEAR or SCAN)
 - scan_done  out  1  one-cycle pulse with last scan word
 - addr_err  out  1  one-cycle pulse on rejected out-of-range request

Function
REQ-003 Storage SHALL be ROWS x COLS words of WIDTH bits, row-major, addressed [row][col].
REQ-004 FSM states SHALL be IDLE, CLEAR, SCAN; busy = 1 exactly when state is CLEAR or SCAN.
REQ-005 In IDLE, request priority SHALL be clr_start > scan_start > single access (en).
REQ-006 Single access (IDLE, en=1, in-range): edge N latches rdata = mem[row][col] as held before edge N (read-old-data), rvalid=1 for the cycle after edge N; if we=1, mem[row][col] is written at edge N with the mux-selected source.
REQ-007 Write-source mux SHALL be combinational from inmuxsel; the value written is the value present at the writing edge.
REQ-008 If IDLE, en=0, and no start is asserted, rvalid SHALL be 0 and rdata SHALL hold its value.
REQ-009 Out-of-range single access (row>=ROWS or col>=COLS): no write, rdata held, rvalid=0, addr_err=1 for one cycle.
REQ-010 clr_start in IDLE: enter CLEAR; write 0 to one entry per cycle in row-major order (0,0)..(ROWS-1,COLS-1), ROWS*COLS cycles, then return to IDLE; rvalid=0 throughout.
REQ-011 scan_start in IDLE with scan_row<ROWS: enter SCAN; over the following COLS cycles rdata = mem[scan_row][0..COLS-1] in column order, rvalid=1 each cycle; scan_done=1 with the last word; return to IDLE.
REQ-012 scan_start with scan_row>=ROWS: stay in IDLE, addr_err pulse, rvalid=0.
REQ-013 While busy, en, we, clr_start and scan_start SHALL be ignored; memory is modified only by CLEAR.
REQ-014 Internal row/column counters SHALL wrap column COLS-1 -> 0 with row increment; no entry outside the array is ever written.
REQ-015 The first single access is accepted in the cycle after return to IDLE.

Reset
REQ-016 rst=1 SHALL asynchronously force state IDLE, counters 0, rdata=0, rvalid=0, busy=0, scan_done=0, addr_err=0.
REQ-017 Memory contents SHALL NOT be reset; rst during CLEAR aborts it, leaving entries already written at 0 and the rest unchanged.

Verification
REQ-018 Write (2,3) with inmuxsel=0, m2result=0x1234; then read (2,3) -> first rdata = old value, next read rdata=0x1234, rvalid=1.
REQ-019 Write (9,9) with inmuxsel=1, lutdata=0xBEEF; read (9,9) -> 0xBEEF; access (10,0) -> addr_err=1 one cycle, no write, rdata unchanged.
REQ-020 Fill row 4 with values 0x40+col, scan_start with scan_row=4 -> 10 rvalid cycles with rdata 0x40..0x49, scan_done on 0x49, busy=0 afterwards.
REQ-021 Fill array, pulse clr_start -> busy=1 for exactly 100 cycles; subsequent reads of all entries return 0.
REQ-022 Assert rst on CLEAR cycle 15 -> outputs 0 immediately, entries (0,0)..(1,4) = 0, (1,5) onward retain prior values.
REQ-023 Assert clr_start and scan_start together in IDLE -> CLEAR taken; we=1 during busy -> no write occurs.

Source files
------------

// File: rtl/grid_sram_seq.sv
// ROWS x COLS word store with single-cycle access port and a sequencer
// that either zero-fills the whole array or streams one row out.
module grid_sram_seq #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 10,
    parameter int COLS  = 10,
    parameter int RW    = 4,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [RW-1:0]    row,
    input  logic [CW-1:0]    col,
    input  logic [WIDTH-1:0] m2result,
    input  logic [WIDTH-1:0] lutdata,
    input  logic             inmuxsel,
    input  logic             clr_start,
    input  logic             scan_start,
    input  logic [RW-1:0]    scan_row,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy,
    output logic             scan_done,
    output logic             addr_err
);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;

    localparam int RW1 = RW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [RW:0]   ROW_LIM  = RW1'(ROWS);
    localparam logic [CW:0]   COL_LIM  = CW1'(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t           state;
    logic [RW-1:0]    r_cnt;
    logic [CW-1:0]    c_cnt;
    logic [WIDTH-1:0] mem [ROWS][COLS];

    logic             acc_ok;
    logic             scan_ok;
    logic [WIDTH-1:0] wsrc;
    logic             mem_we;
    logic [RW-1:0]    mem_r;
    logic [CW-1:0]    mem_c;
    logic [WIDTH-1:0] mem_d;

    assign acc_ok  = ({1'b0, row} < ROW_LIM) && ({1'b0, col} < COL_LIM);
    assign scan_ok = ({1'b0, scan_row} < ROW_LIM);
    assign wsrc    = inmuxsel ? lutdata : m2result;

    // Write port is shared by the clear sequencer and single-access writes;
    // reset blocks writes so an aborted clear stops immediately.
    always_comb begin
        mem_we = 1'b0;
        mem_r  = row;
        mem_c  = col;
        mem_d  = wsrc;
        if (!rst) begin
            case (state)
                CLEAR: begin
                    mem_we = 1'b1;
                    mem_r  = r_cnt;
                    mem_c  = c_cnt;
                    mem_d  = '0;
                end
                IDLE: begin
                    if (!clr_start && !scan_start && en && we && acc_ok)
                        mem_we = 1'b1;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_r][mem_c] <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r_cnt     <= '0;
            c_cnt     <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            rvalid    <= 1'b0;
            scan_done <= 1'b0;
            addr_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        r_cnt <= '0;
                        c_cnt <= '0;
                    end else if (scan_start) begin
                        if (scan_ok) begin
                            state <= SCAN;
                            busy  <= 1'b1;
                            r_cnt <= scan_row;
                            c_cnt <= '0;
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end else if (en) begin
                        if (acc_ok) begin
                            rdata  <= mem[row][col];
                            rvalid <= 1'b1;
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (c_cnt == COL_LAST) begin
                        c_cnt <= '0;
                        if (r_cnt == ROW_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        c_cnt <= c_cnt + 1'b1;
                    end
                end
                SCAN: begin
                    rdata  <= mem[r_cnt][c_cnt];
                    rvalid <= 1'b1;
                    if (c_cnt == COL_LAST) begin
                        scan_done <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        r_cnt     <= '0;
                        c_cnt     <= '0;
                    end else begin
                        c_cnt <= c_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_sram_seq.sv
// Randomized bench for grid_sram_seq against an array-based reference model.
`timescale 1ns/1ps
module tb_grid_sram_seq;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] m2result;
    logic [15:0] lutdata;
    logic        inmuxsel;
    logic        clr_start;
    logic        scan_start;
    logic [3:0]  scan_row;
    logic [15:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        scan_done;
    logic        addr_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mdl [10][10];
    logic [15:0] exp_rdata;

    grid_sram_seq #(.WIDTH(16), .ROWS(10), .COLS(10), .RW(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .row(row), .col(col),
        .m2result(m2result), .lutdata(lutdata), .inmuxsel(inmuxsel),
        .clr_start(clr_start), .scan_start(scan_start), .scan_row(scan_row),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .scan_done(scan_done),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; we = 1'b0; clr_start = 1'b0; scan_start = 1'b0;
    endtask

    task automatic do_access(input int r, input int c, input bit w, input bit sel,
                             input logic [15:0] m2, input logic [15:0] lut);
        en = 1'b1; we = w; row = 4'(r); col = 4'(c);
        inmuxsel = sel; m2result = m2; lutdata = lut;
        step();
        idle_inputs();
        if (r < 10 && c < 10) begin
            exp_rdata = mdl[r][c];
            if (w) mdl[r][c] = sel ? lut : m2;
            check("acc_rvalid", 32'(rvalid), 32'(1));
            check("acc_err", 32'(addr_err), 32'(0));
        end else begin
            check("oor_rvalid", 32'(rvalid), 32'(0));
            check("oor_err", 32'(addr_err), 32'(1));
        end
        check("acc_rdata", 32'(rdata), 32'(exp_rdata));
        check("acc_busy", 32'(busy), 32'(0));
    endtask

    task automatic idle_cycle();
        idle_inputs();
        m2result = 16'($urandom);
        step();
        check("idle_rvalid", 32'(rvalid), 32'(0));
        check("idle_rdata", 32'(rdata), 32'(exp_rdata));
        check("idle_err", 32'(addr_err), 32'(0));
    endtask

    // Stray single-access requests are held during the scan; none may land.
    task automatic do_scan(input int r);
        scan_start = 1'b1; scan_row = 4'(r);
        en = 1'b1; we = 1'b1; row = 4'($urandom_range(0, 9)); col = 4'($urandom_range(0, 9));
        m2result = 16'($urandom); lutdata = 16'($urandom); inmuxsel = 1'($urandom);
        step();
        scan_start = 1'b0;
        if (r >= 10) begin
            idle_inputs();
            check("bad_scan_err", 32'(addr_err), 32'(1));
            check("bad_scan_rvalid", 32'(rvalid), 32'(0));
            check("bad_scan_busy", 32'(busy), 32'(0));
            check("bad_scan_rdata", 32'(rdata), 32'(exp_rdata));
        end else begin
            check("scan_busy0", 32'(busy), 32'(1));
            check("scan_rvalid0", 32'(rvalid), 32'(0));
            for (int c = 0; c < 10; c++) begin
                step();
                check("scan_rvalid", 32'(rvalid), 32'(1));
                check("scan_rdata", 32'(rdata), 32'(mdl[r][c]));
                check("scan_done", 32'(scan_done), 32'(c == 9));
                check("scan_busy", 32'(busy), 32'(c < 9));
            end
            exp_rdata = mdl[r][9];
            idle_inputs();
            step();
            check("scan_after_busy", 32'(busy), 32'(0));
            check("scan_after_done", 32'(scan_done), 32'(0));
            check("scan_after_rvalid", 32'(rvalid), 32'(0));
        end
    endtask

    task automatic do_clear(input bit with_scan);
        int cnt;
        int rv_seen;
        clr_start = 1'b1; scan_start = with_scan; scan_row = 4'($urandom_range(0, 9));
        en = 1'b1; we = 1'b1; row = 4'($urandom_range(0, 9)); col = 4'($urandom_range(0, 9));
        m2result = 16'($urandom | 1); lutdata = 16'($urandom | 1); inmuxsel = 1'($urandom);
        step();
        clr_start = 1'b0; scan_start = 1'b0;
        cnt = 0;
        rv_seen = 0;
        if (rvalid) rv_seen++;
        while (busy && cnt < 200) begin
            cnt++;
            step();
            if (rvalid) rv_seen++;
        end
        idle_inputs();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                mdl[r][c] = '0;
        check("clear_busy_cycles", 32'(cnt), 32'(100));
        check("clear_rvalid_seen", 32'(rv_seen), 32'(0));
    endtask

    task automatic fill_random();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                do_access(r, c, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic read_all();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                do_access(r, c, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        row = '0; col = '0; scan_row = '0;
        m2result = '0; lutdata = '0; inmuxsel = 1'b0;
        exp_rdata = '0;
        repeat (3) step();
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(scan_done), 32'(0));
        check("rst_err", 32'(addr_err), 32'(0));
        rst = 1'b0;
        step();

        // Known contents, and clr_start wins over a simultaneous scan_start
        do_clear(1'b1);
        read_all();

        do_access(2, 3, 1'b1, 1'b0, 16'h1234, 16'h5555);
        do_access(2, 3, 1'b0, 1'b0, 16'h0, 16'h0);
        check("r23_value", 32'(rdata), 32'h1234);

        do_access(9, 9, 1'b1, 1'b1, 16'h7777, 16'hBEEF);
        do_access(9, 9, 1'b0, 1'b0, 16'h0, 16'h0);
        check("r99_value", 32'(rdata), 32'hBEEF);
        do_access(10, 0, 1'b1, 1'b0, 16'hDEAD, 16'hDEAD);
        check("oor_hold", 32'(rdata), 32'hBEEF);
        do_access(0, 10, 1'b1, 1'b1, 16'hDEAD, 16'hDEAD);
        idle_cycle();
        check("err_one_cycle", 32'(addr_err), 32'(0));

        for (int c = 0; c < 10; c++)
            do_access(4, c, 1'b1, 1'b0, 16'(32'h40 + c), 16'h0);
        do_scan(4);
        check("scan4_last", 32'(rdata), 32'h49);
        do_scan(12);

        fill_random();
        do_clear(1'b0);
        read_all();

        // Abort a clear partway: entries 0..14 cleared, the rest untouched
        fill_random();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (15) step();
        rst = 1'b1;
        #1;
        check("abort_rdata", 32'(rdata), 32'(0));
        check("abort_rvalid", 32'(rvalid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(scan_done), 32'(0));
        check("abort_err", 32'(addr_err), 32'(0));
        #1;
        rst = 1'b0;
        exp_rdata = '0;
        for (int i = 0; i < 15; i++)
            mdl[i / 10][i % 10] = '0;
        read_all();

        for (int it = 0; it < 400; it++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k == 0)
                idle_cycle();
            else if (k == 1)
                do_scan(int'($urandom_range(0, 11)));
            else
                do_access(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                          1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
